apb_master: RTL and testbench

- APB initiator (bridge) between the CPU-side bus and up to four APB responders, e.g. the RAM and peripheral blocks.
- Accepts single-cycle read/write requests, decodes the address to one PSEL, and runs a standard SETUP/ACCESS transfer.
- Waits for the selected PREADY, then returns read data with a one-cycle completion pulse.
- Unmapped addresses and hung responders (timeout) complete with an error flag.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master_if.sv | 47 ++++
 rtl/apb_addr_decoder.sv | 21 ++
 rtl/apb_master.sv | 130 +++++++++++++
 tb/tb_apb_master.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB bridge types and slot-map constants.
package apb_pkg;

    localparam int unsigned APB_SLOT_BITS      = 2;
    localparam int unsigned APB_NUM_SLOTS      = 4;
    localparam int unsigned APB_SLOT_SIZE_LOG2 = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// CPU-side request/response and APB bus signals of the bridge, grouped as one bundle.
interface apb_master_if;

    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        err;
    logic [31:0] rdata;

    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL0;
    logic        PSEL1;
    logic        PSEL2;
    logic        PSEL3;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        input  transfer, write, addr, wdata,
        output ready, err, rdata,
        output PADDR, PWDATA, PWRITE, PENABLE,
        output PSEL0, PSEL1, PSEL2, PSEL3,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        output transfer, write, addr, wdata,
        input  ready, err, rdata,
        input  PADDR, PWDATA, PWRITE, PENABLE,
        input  PSEL0, PSEL1, PSEL2, PSEL3,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto the 16 KB APB window: hit flag plus 4 KB slot index.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic [31:0]              addr,
    output logic                     hit,
    output logic [APB_SLOT_BITS-1:0] slot
);

    localparam int unsigned WIN_LSB = APB_SLOT_SIZE_LOG2 + APB_SLOT_BITS;

    // Offset within a slot is the responder's business, not the decoder's.
    logic unused_offset_bits;

    assign hit  = (addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    assign slot = addr[WIN_LSB-1:APB_SLOT_SIZE_LOG2];
    assign unused_offset_bits = ^addr[APB_SLOT_SIZE_LOG2-1:0];

endmodule

// File: rtl/apb_master.sv
// APB initiator: decodes a CPU request to one of four responders, runs SETUP/ACCESS,
// and returns a one-cycle ready pulse with read data or an error (unmapped/timeout).
module apb_master
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_master_if.master    bus
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e               state;
    logic [APB_SLOT_BITS-1:0] slot_q;
    logic [CW-1:0]            tcnt;

    logic                     dec_hit;
    logic [APB_SLOT_BITS-1:0] dec_slot;

    logic                     ready_q;
    logic                     err_q;
    logic [31:0]              rdata_q;
    logic [31:0]              paddr_q;
    logic [31:0]              pwdata_q;
    logic                     pwrite_q;

    logic [APB_NUM_SLOTS-1:0] psel_vec;
    logic                     sel_pready;
    logic [31:0]              sel_prdata;

    apb_addr_decoder #(
        .BASE_ADDR (BASE_ADDR)
    ) u_dec (
        .addr (bus.addr),
        .hit  (dec_hit),
        .slot (dec_slot)
    );

    // Only the registered slot is looked at, so other responders cannot complete us.
    always_comb begin
        sel_pready = 1'b0;
        sel_prdata = '0;
        case (slot_q)
            2'd0: begin sel_pready = bus.PREADY0; sel_prdata = bus.PRDATA0; end
            2'd1: begin sel_pready = bus.PREADY1; sel_prdata = bus.PRDATA1; end
            2'd2: begin sel_pready = bus.PREADY2; sel_prdata = bus.PRDATA2; end
            default: begin sel_pready = bus.PREADY3; sel_prdata = bus.PRDATA3; end
        endcase
    end

    always_comb begin
        psel_vec = '0;
        if (state == SETUP || state == ACCESS) begin
            psel_vec[slot_q] = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            slot_q   <= '0;
            tcnt     <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.transfer) begin
                        if (dec_hit) begin
                            paddr_q  <= bus.addr;
                            pwdata_q <= bus.wdata;
                            pwrite_q <= bus.write;
                            slot_q   <= dec_slot;
                            state    <= SETUP;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                SETUP: begin
                    tcnt  <= '0;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (sel_pready) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        rdata_q <= pwrite_q ? '0 : sel_prdata;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ERROR: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PSEL0   = psel_vec[0];
    assign bus.PSEL1   = psel_vec[1];
    assign bus.PSEL2   = psel_vec[2];
    assign bus.PSEL3   = psel_vec[3];

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: RAM-like responders with configurable wait states,
// a transaction-level timing/data model, directed scenarios and randomized traffic.
module tb_apb_master;

    localparam int unsigned TO = 16;

    logic PCLK = 1'b0;
    logic PRESET;

    apb_master_if bus();

    apb_master #(
        .BASE_ADDR (32'h1000_0000),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Responders: selected slot answers after resp_delay extra ACCESS cycles (registered
    // PREADY); everything unselected, and SETUP data, is random noise.
    logic [31:0] rmem [4096];
    logic [3:0]  pr_ready;
    logic [31:0] pr_data [4];
    int unsigned wcnt [4];
    int unsigned resp_delay;
    logic [3:0]  psel_v;

    assign psel_v = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};
    assign bus.PREADY0 = pr_ready[0];
    assign bus.PREADY1 = pr_ready[1];
    assign bus.PREADY2 = pr_ready[2];
    assign bus.PREADY3 = pr_ready[3];
    assign bus.PRDATA0 = pr_data[0];
    assign bus.PRDATA1 = pr_data[1];
    assign bus.PRDATA2 = pr_data[2];
    assign bus.PRDATA3 = pr_data[3];

    initial begin
        for (int i = 0; i < 4096; i++) rmem[i] = '0;
        pr_ready = '0;
        for (int n = 0; n < 4; n++) begin
            pr_data[n] = '0;
            wcnt[n] = 0;
        end
    end

    always @(posedge PCLK) begin
        for (int n = 0; n < 4; n++) begin
            if (psel_v[n] && bus.PENABLE) begin
                if (pr_ready[n]) begin
                    pr_ready[n] <= 1'b0;
                    wcnt[n] <= 0;
                end else if (wcnt[n] == resp_delay) begin
                    pr_ready[n] <= 1'b1;
                    if (bus.PWRITE) rmem[{n[1:0], bus.PADDR[11:2]}] <= bus.PWDATA;
                    else pr_data[n] <= rmem[{n[1:0], bus.PADDR[11:2]}];
                end else begin
                    wcnt[n] <= wcnt[n] + 1;
                    pr_ready[n] <= 1'b0;
                    pr_data[n] <= $urandom;
                end
            end else if (psel_v[n]) begin
                pr_ready[n] <= 1'b0;
                wcnt[n] <= 0;
                pr_data[n] <= $urandom;
            end else begin
                pr_ready[n] <= 1'($urandom);
                pr_data[n] <= $urandom;
                wcnt[n] <= 0;
            end
        end
    end

    // Transaction-level model: an accepted request in cycle c has SETUP in c+1; a mapped one
    // spends min(delay+2, TO) cycles in ACCESS, an unmapped one a single ERROR cycle.
    bit          chk_en = 1'b0;
    bit          have_txn = 1'b0;
    int unsigned t_acc = 0, t_done = 0, t_slot = 0;
    bit          t_mapped = 1'b0, t_err = 1'b0;
    logic [31:0] t_rdata = '0;
    logic [31:0] e_paddr = '0, e_pwdata = '0, e_rdata = '0;
    logic        e_pwrite = 1'b0;
    logic [31:0] mm [int unsigned];
    int unsigned idle_at = 0;

    always @(negedge PCLK) begin : compare
        automatic bit          win;
        automatic bit          rdy;
        automatic logic [3:0]  esel;
        automatic logic [31:0] off;
        automatic int unsigned key;
        automatic int unsigned alen;
        if (chk_en) begin
            win  = have_txn && t_mapped && cyc >= t_acc && cyc < t_done;
            esel = win ? 4'(1 << t_slot) : 4'b0;
            rdy  = have_txn && cyc == t_done;
            if (rdy) e_rdata = t_rdata;
            chk("ready",   32'(bus.ready),   32'(rdy));
            chk("err",     32'(bus.err),     32'(rdy && t_err));
            chk("rdata",   bus.rdata,        e_rdata);
            chk("psel",    32'(psel_v),      32'(esel));
            chk("penable", 32'(bus.PENABLE), 32'(win && cyc > t_acc));
            chk("paddr",   bus.PADDR,        e_paddr);
            chk("pwdata",  bus.PWDATA,       e_pwdata);
            chk("pwrite",  32'(bus.PWRITE),  32'(e_pwrite));
            if (PRESET) begin
                have_txn = 1'b0;
                e_paddr  = '0;
                e_pwdata = '0;
                e_pwrite = 1'b0;
                e_rdata  = '0;
            end else if (bus.transfer && (!have_txn || cyc >= t_done)) begin
                off      = bus.addr - 32'h1000_0000;
                have_txn = 1'b1;
                t_acc    = cyc + 1;
                t_mapped = (off < 32'h4000);
                if (!t_mapped) begin
                    t_done  = cyc + 2;
                    t_err   = 1'b1;
                    t_rdata = '0;
                end else begin
                    alen     = (resp_delay + 2 < TO) ? resp_delay + 2 : TO;
                    t_done   = cyc + 2 + alen;
                    t_err    = (resp_delay + 2 > TO);
                    t_slot   = off / 4096;
                    key      = off / 4;
                    e_paddr  = bus.addr;
                    e_pwdata = bus.wdata;
                    e_pwrite = bus.write;
                    if (t_err || bus.write) t_rdata = '0;
                    else t_rdata = mm.exists(key) ? mm[key] : '0;
                    if (bus.write && !t_err) mm[key] = bus.wdata;
                end
            end
            idle_at = have_txn ? t_done : 0;
        end
    end

    // Issues one request and checks latency/err/rdata/selects against hand-computed values.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input int unsigned d, input int unsigned exp_lat, input logic exp_err,
                        input logic [31:0] exp_rd, input logic [3:0] exp_sel);
        int unsigned lat;
        logic [3:0]  seen;
        bus.transfer = 1'b1;
        bus.write    = w;
        bus.addr     = a;
        bus.wdata    = wd;
        resp_delay   = d;
        lat  = 0;
        seen = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge PCLK); #1;
            if (k == 1) bus.transfer = 1'b0;
            @(negedge PCLK);
            seen |= psel_v;
            if (bus.ready) begin
                lat = k;
                break;
            end
        end
        chk("lat",      lat,          exp_lat);
        chk("done_err", 32'(bus.err), 32'(exp_err));
        chk("done_rd",  bus.rdata,    exp_rd);
        chk("sel_seen", 32'(seen),    32'(exp_sel));
        @(posedge PCLK); #1;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        PRESET = 1'b1;
        bus.transfer = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        resp_delay = 0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        chk_en = 1'b1;
        @(negedge PCLK);
        chk("rst_psel",    32'(psel_v),      32'h0);
        chk("rst_penable", 32'(bus.PENABLE), 32'h0);
        chk("rst_ready",   32'(bus.ready),   32'h0);
        chk("rst_err",     32'(bus.err),     32'h0);
        chk("rst_rdata",   bus.rdata,        32'h0);
        chk("rst_paddr",   bus.PADDR,        32'h0);
        @(posedge PCLK); #1;

        xfer(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 4, 1'b0, 32'h0, 4'b0001);
        xfer(1'b0, 32'h1000_0010, 32'h0, 0, 4, 1'b0, 32'hDEAD_BEEF, 4'b0001);

        xfer(1'b1, 32'h1000_1000, 32'h11, 1, 5, 1'b0, 32'h0, 4'b0010);
        xfer(1'b1, 32'h1000_2000, 32'h22, 0, 4, 1'b0, 32'h0, 4'b0100);
        xfer(1'b1, 32'h1000_3000, 32'h33, 2, 6, 1'b0, 32'h0, 4'b1000);
        xfer(1'b0, 32'h1000_1000, 32'h0, 0, 4, 1'b0, 32'h11, 4'b0010);
        xfer(1'b0, 32'h1000_2000, 32'h0, 3, 7, 1'b0, 32'h22, 4'b0100);
        xfer(1'b0, 32'h1000_3000, 32'h0, 0, 4, 1'b0, 32'h33, 4'b1000);
        xfer(1'b1, 32'h1000_3FFC, 32'h5A5A_0F0F, 0, 4, 1'b0, 32'h0, 4'b1000);
        xfer(1'b0, 32'h1000_3FFC, 32'h0, 0, 4, 1'b0, 32'h5A5A_0F0F, 4'b1000);

        xfer(1'b0, 32'h2000_0000, 32'h0, 0, 2, 1'b1, 32'h0, 4'b0000);
        xfer(1'b1, 32'h1000_4000, 32'h77, 0, 2, 1'b1, 32'h0, 4'b0000);
        xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 0, 2, 1'b1, 32'h0, 4'b0000);

        xfer(1'b0, 32'h1000_0010, 32'h0, 1000, 18, 1'b1, 32'h0, 4'b0001);
        xfer(1'b0, 32'h1000_0010, 32'h0, 0, 4, 1'b0, 32'hDEAD_BEEF, 4'b0001);
        xfer(1'b0, 32'h1000_1000, 32'h0, 14, 18, 1'b0, 32'h11, 4'b0010);

        // Back-to-back: transfer held through SETUP/ACCESS (ignored), new request in ready cycle.
        bus.transfer = 1'b1; bus.write = 1'b1; bus.addr = 32'h1000_2004;
        bus.wdata = 32'hA5A5_0001; resp_delay = 0;
        @(posedge PCLK); #1;
        bus.write = 1'b1; bus.addr = 32'h1000_3008; bus.wdata = 32'h0BAD_0BAD;
        repeat (3) begin @(posedge PCLK); #1; end
        bus.write = 1'b0; bus.addr = 32'h1000_2004;
        @(negedge PCLK);
        chk("b2b_ready", 32'(bus.ready), 32'h1);
        chk("b2b_paddr", bus.PADDR,      32'h1000_2004);
        @(posedge PCLK); #1;
        bus.transfer = 1'b0;
        @(negedge PCLK);
        chk("b2b_setup_psel", 32'(psel_v),      32'h4);
        chk("b2b_setup_pen",  32'(bus.PENABLE), 32'h0);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge PCLK);
            if (bus.ready) begin n = k; break; end
        end
        chk("b2b_lat",   n,         32'd3);
        chk("b2b_rdata", bus.rdata, 32'hA5A5_0001);
        @(posedge PCLK); #1;

        // Reset in the middle of ACCESS against a hung responder.
        bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_1000; resp_delay = 1000;
        @(posedge PCLK); #1;
        bus.transfer = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("mrst_psel",  32'(psel_v),      32'h0);
        chk("mrst_pen",   32'(bus.PENABLE), 32'h0);
        chk("mrst_ready", 32'(bus.ready),   32'h0);
        chk("mrst_rdata", bus.rdata,        32'h0);
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h1000_1000, 32'h0, 0, 4, 1'b0, 32'h11, 4'b0010);

        for (int i = 0; i < 3000; i++) begin
            if (cyc >= idle_at) begin
                if ($urandom_range(0, 2) == 0) begin
                    n = $urandom_range(0, 3);
                    bus.transfer = 1'b1;
                    bus.write    = 1'($urandom);
                    if ($urandom_range(0, 9) == 0) bus.addr = $urandom;
                    else bus.addr = 32'h1000_0000 + 32'(n * 4096) + 32'($urandom_range(0, 7) * 4);
                    bus.wdata    = $urandom;
                    resp_delay   = ($urandom_range(0, 19) == 0) ? 1000 : $urandom_range(0, 5);
                end else begin
                    bus.transfer = 1'b0;
                end
            end else begin
                bus.transfer = ($urandom_range(0, 5) == 0);
                bus.write    = 1'($urandom);
                bus.addr     = $urandom;
                bus.wdata    = $urandom;
            end
            @(posedge PCLK); #1;
        end
        bus.transfer = 1'b0;
        repeat (25) @(posedge PCLK);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
